// File: rtl/mdu_pkg.sv
// Operation codes, FSM states and op-class helpers for the iterative HI/LO multiply/divide unit.
package mdu_pkg;

    localparam logic [3:0] MULT  = 4'd0;
    localparam logic [3:0] MULTU = 4'd1;
    localparam logic [3:0] DIV   = 4'd2;
    localparam logic [3:0] DIVU  = 4'd3;
    localparam logic [3:0] MADD  = 4'd4;
    localparam logic [3:0] MADDU = 4'd5;
    localparam logic [3:0] MSUB  = 4'd6;
    localparam logic [3:0] MSUBU = 4'd7;
    localparam logic [3:0] MTHI  = 4'd8;
    localparam logic [3:0] MTLO  = 4'd9;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ITER,
        S_FIX,
        S_DONE
    } state_e;

    function automatic logic is_valid(input logic [3:0] op);
        return op <= MTLO;
    endfunction

    // Signed variants sit on even codes within the arithmetic range.
    function automatic logic is_signed(input logic [3:0] op);
        return (op < MTHI) && !op[0];
    endfunction

    function automatic logic is_div(input logic [3:0] op);
        return (op == DIV) || (op == DIVU);
    endfunction

    function automatic logic is_acc(input logic [3:0] op);
        return (op >= MADD) && (op <= MSUBU);
    endfunction

    function automatic logic is_sub(input logic [3:0] op);
        return (op == MSUB) || (op == MSUBU);
    endfunction

endpackage

// File: rtl/mdu_iter_step.sv
// One radix-2 iteration on magnitudes: shift-add multiply or restoring divide over a {hi,lo} pair.
module mdu_iter_step #(
    parameter int WIDTH = 32
) (
    input  logic             div_i,
    input  logic [WIDTH-1:0] hi_i,
    input  logic [WIDTH-1:0] lo_i,
    input  logic [WIDTH-1:0] m_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] shl;
    logic [WIDTH:0] rem;
    logic           ge;

    always_comb begin
        sum  = {1'b0, hi_i} + (lo_i[0] ? {1'b0, m_i} : '0);
        shl  = {hi_i, lo_i[WIDTH-1]};
        ge   = shl >= {1'b0, m_i};
        rem  = shl - {1'b0, m_i};
        hi_o = sum[WIDTH:1];
        lo_o = {sum[0], lo_i[WIDTH-1:1]};
        if (div_i) begin
            // Partial remainder stays below the divisor, so the top bit is always zero here.
            hi_o = WIDTH'(ge ? rem : shl);
            lo_o = {lo_i[WIDTH-2:0], ge};
        end
    end

endmodule

// File: rtl/mdu_hilo_iter.sv
// Multi-cycle multiply/divide unit owning HI/LO: IDLE -> ITER (WIDTH steps) -> FIX (sign/accumulate/commit) -> DONE.
module mdu_hilo_iter
    import mdu_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic [3:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Flush,
    output logic             Busy,
    output logic             Done,
    output logic             DivByZero,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [3:0]         op_q;
    logic               neg_q, rneg_q, dz_q;
    logic [WIDTH-1:0]   m_q, wh_q, wl_q, hi_q, lo_q;
    logic               busy_q, done_q, dbz_q;

    logic               accept, a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag, step_hi, step_lo, quot_d, rem_d;
    logic [2*WIDTH-1:0] prod_s, hilo_d;

    mdu_iter_step #(.WIDTH(WIDTH)) u_step (
        .div_i (is_div(op_q)),
        .hi_i  (wh_q),
        .lo_i  (wl_q),
        .m_i   (m_q),
        .hi_o  (step_hi),
        .lo_o  (step_lo)
    );

    always_comb begin
        accept = Start && !Flush && is_valid(Op) && (state_q == S_IDLE || state_q == S_DONE);
        a_neg  = is_signed(Op) && A[WIDTH-1];
        b_neg  = is_signed(Op) && B[WIDTH-1];
        a_mag  = a_neg ? -A : A;
        b_mag  = b_neg ? -B : B;
        prod_s = neg_q ? -{wh_q, wl_q} : {wh_q, wl_q};
        hilo_d = prod_s;
        if (is_acc(op_q)) begin
            hilo_d = is_sub(op_q) ? {hi_q, lo_q} - prod_s : {hi_q, lo_q} + prod_s;
        end
        quot_d = neg_q ? -wl_q : wl_q;
        rem_d  = rneg_q ? -wh_q : wh_q;
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
            m_q     <= '0;
            wh_q    <= '0;
            wl_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    state_q <= S_IDLE;
                    if (accept) begin
                        op_q <= Op;
                        if (Op == MTHI) begin
                            hi_q    <= A;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else if (Op == MTLO) begin
                            lo_q    <= A;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            state_q <= S_ITER;
                            busy_q  <= 1'b1;
                            cnt_q   <= CNT_W'(WIDTH - 1);
                            neg_q   <= a_neg ^ b_neg;
                            rneg_q  <= a_neg;
                            dz_q    <= is_div(Op) && (B == '0);
                            wh_q    <= '0;
                            wl_q    <= is_div(Op) ? a_mag : b_mag;
                            m_q     <= is_div(Op) ? b_mag : a_mag;
                        end
                    end
                end
                S_ITER: begin
                    if (Flush) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        wh_q  <= step_hi;
                        wl_q  <= step_lo;
                        cnt_q <= cnt_q - CNT_W'(1);
                        if (cnt_q == '0) state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    busy_q <= 1'b0;
                    if (Flush) begin
                        state_q <= S_IDLE;
                    end else begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        dbz_q   <= dz_q;
                        if (!is_div(op_q)) begin
                            {hi_q, lo_q} <= hilo_d;
                        end else if (!dz_q) begin
                            hi_q <= rem_d;
                            lo_q <= quot_d;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign Busy      = busy_q;
    assign Done      = done_q;
    assign DivByZero = dbz_q;
    assign Hi        = hi_q;
    assign Lo        = lo_q;

endmodule

// File: tb/tb_mdu_hilo_iter.sv
// Self-checking bench for mdu_hilo_iter (WIDTH=32) against a plain-arithmetic HI/LO reference model.
module tb_mdu_hilo_iter;

    localparam int W = 32;

    logic          Clk = 1'b0;
    logic          Rst = 1'b0;
    logic          Start = 1'b0;
    logic [3:0]    Op = 4'd0;
    logic [W-1:0]  A = '0;
    logic [W-1:0]  B = '0;
    logic          Flush = 1'b0;
    logic          Busy, Done, DivByZero;
    logic [W-1:0]  Hi, Lo;

    int            checks = 0;
    int            errors = 0;
    int            cyc, busy_cnt, done_cyc, done_n;

    logic [W-1:0]  m_hi, m_lo;
    logic [63:0]   e_hilo;
    logic          e_dz;

    mdu_hilo_iter #(.WIDTH(W)) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .Start     (Start),
        .Op        (Op),
        .A         (A),
        .B         (B),
        .Flush     (Flush),
        .Busy      (Busy),
        .Done      (Done),
        .DivByZero (DivByZero),
        .Hi        (Hi),
        .Lo        (Lo)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
        cyc++;
        if (Busy) busy_cnt++;
        if (Done) begin
            done_n++;
            if (done_cyc == 0) done_cyc = cyc;
        end
    endtask

    // Reference result of an op applied to the current model HI/LO.
    task automatic model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        longint      sa, sb, q, r;
        logic [63:0] acc, sp, up;
        acc = {m_hi, m_lo};
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        sp  = sa * sb;
        up  = {32'd0, a} * {32'd0, b};
        e_dz   = 1'b0;
        e_hilo = acc;
        case (op)
            4'd0: e_hilo = sp;
            4'd1: e_hilo = up;
            4'd2: if (b == 0) e_dz = 1'b1;
                  else begin
                      q = sa / sb;
                      r = sa % sb;
                      e_hilo = {r[31:0], q[31:0]};
                  end
            4'd3: if (b == 0) e_dz = 1'b1;
                  else e_hilo = {a % b, a / b};
            4'd4: e_hilo = acc + sp;
            4'd5: e_hilo = acc + up;
            4'd6: e_hilo = acc - sp;
            4'd7: e_hilo = acc - up;
            4'd8: e_hilo = {a, m_lo};
            4'd9: e_hilo = {m_hi, a};
            default: ;
        endcase
    endtask

    task automatic start(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        Op = op; A = a; B = b; Start = 1'b1;
        cyc = 0; busy_cnt = 0; done_cyc = 0; done_n = 0;
        tick();
        Start = 1'b0;
        Op = 4'($urandom);
        A  = $urandom;
        B  = $urandom;
    endtask

    task automatic wait_done(input string tag, input int exp_cyc, input int exp_busy);
        while (done_cyc == 0 && cyc < 200) tick();
        check({tag, ".latency"}, 64'(done_cyc), 64'(exp_cyc));
        check({tag, ".busy"}, 64'(busy_cnt), 64'(exp_busy));
    endtask

    task automatic run(input string tag, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        model(op, a, b);
        start(op, a, b);
        if (op >= 4'd8) wait_done(tag, 1, 0);
        else            wait_done(tag, W + 2, W + 1);
        check({tag, ".hilo"}, {Hi, Lo}, e_hilo);
        check({tag, ".dbz"}, 64'(DivByZero), 64'(e_dz));
        {m_hi, m_lo} = e_hilo;
    endtask

    initial begin
        logic [3:0]   rop;
        logic [W-1:0] ra, rb;

        m_hi = '0;
        m_lo = '0;
        tick();
        tick();
        check("reset", {Hi, Lo, 29'd0, Busy, Done, DivByZero}, '0);
        Rst = 1'b1;
        tick();

        run("mult_neg1x7", 4'd0, 32'hFFFFFFFF, 32'd7);
        check("mult_neg1x7.const", {Hi, Lo}, 64'hFFFFFFFF_FFFFFFF9);
        run("div_neg7_2", 4'd2, 32'hFFFFFFF9, 32'd2);
        check("div_neg7_2.const", {Hi, Lo}, 64'hFFFFFFFF_FFFFFFFD);
        run("divu_by0", 4'd3, 32'd100, 32'd0);

        run("mtlo", 4'd9, 32'hFFFFFFFF, 32'd0);
        run("mthi", 4'd8, 32'd0, 32'd0);
        run("maddu", 4'd5, 32'd1, 32'd1);
        check("maddu.const", {Hi, Lo}, 64'h00000001_00000000);
        run("msub", 4'd6, 32'd1, 32'd1);
        check("msub.const", {Hi, Lo}, 64'h00000000_FFFFFFFF);

        // Flush during ITER with a competing Start.
        run("pre_hi", 4'd8, 32'd1, 32'd0);
        run("pre_lo", 4'd9, 32'd2, 32'd0);
        start(4'd0, 32'd3, 32'd5);
        while (cyc < 10) tick();
        Flush = 1'b1; Start = 1'b1; Op = 4'd1; A = 32'd7; B = 32'd7;
        tick();
        Flush = 1'b0; Start = 1'b0;
        check("flush_iter.done", 64'(done_n), 64'd0);
        check("flush_iter.busy", 64'(Busy), 64'd0);
        check("flush_iter.hilo", {Hi, Lo}, 64'h00000001_00000002);
        run("after_flush", 4'd0, $urandom, $urandom);

        // Flush on the FIX cycle drops the commit.
        start(4'd1, $urandom, $urandom);
        while (cyc < W + 1) tick();
        check("flush_fix.busy_before", 64'(Busy), 64'd1);
        Flush = 1'b1;
        tick();
        Flush = 1'b0;
        tick();
        check("flush_fix.done", 64'(done_n), 64'd0);
        check("flush_fix.hilo", {Hi, Lo}, {m_hi, m_lo});

        // Start while busy is ignored; Start in the Done cycle chains.
        model(4'd1, 32'd4, 32'd5);
        start(4'd1, 32'd4, 32'd5);
        while (cyc < 3) tick();
        Start = 1'b1; Op = 4'd1; A = 32'd2; B = 32'd3;
        tick();
        Start = 1'b0;
        wait_done("busy_start", W + 2, W + 1);
        check("busy_start.hilo", {Hi, Lo}, e_hilo);
        {m_hi, m_lo} = e_hilo;
        run("b2b_divu", 4'd3, 32'd9, 32'd2);
        check("b2b_divu.const", {Hi, Lo}, 64'h00000001_00000004);

        // Flush in the Done cycle: pulse already committed, the Start alongside is dropped.
        Flush = 1'b1; Start = 1'b1; Op = 4'd8; A = 32'hDEADBEEF;
        tick();
        Flush = 1'b0; Start = 1'b0;
        check("flush_done.hilo", {Hi, Lo}, {m_hi, m_lo});
        check("flush_done.done", 64'(Done), 64'd0);

        start(4'd12, $urandom, $urandom);
        repeat (W + 5) tick();
        check("bad_op.done", 64'(done_n), 64'd0);
        check("bad_op.busy", 64'(busy_cnt), 64'd0);

        run("div_min_neg1", 4'd2, 32'h80000000, 32'hFFFFFFFF);
        check("div_min_neg1.const", {Hi, Lo}, 64'h00000000_80000000);

        // Reset in the middle of a divide.
        start(4'd2, 32'hFFFFFF00, 32'd5);
        while (cyc < 5) tick();
        Rst = 1'b0;
        tick();
        check("mid_reset", {Hi, Lo, 30'd0, Busy, Done}, '0);
        Rst = 1'b1;
        m_hi = '0;
        m_lo = '0;
        run("post_reset_mult", 4'd0, $urandom, $urandom);

        for (int i = 0; i < 12; i++) begin
            rop = 4'($urandom_range(0, 9));
            ra  = $urandom;
            rb  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom >> $urandom_range(0, 31);
            run("random", rop, ra, rb);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
